axi_stream_master: RTL

AXI_STREAM_MASTER -- requirements
Module: axi_stream_master

---
 rtl/axi_stream_master.sv | 80 ++++++++
 1 files changed

// File: rtl/axi_stream_master.sv
// axi_stream_master: 2-entry skid FIFO presenting internal-core beats as an AXI-Stream master.
// Handshake outputs are registered so neither ready_internal nor valid sees ready_sys combinationally.
module axi_stream_master #(
  parameter int DATA_WIDTH = 512,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  valid_internal,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  last_in,
  output logic                  ready_internal,
  input  logic                  ready_sys,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  last,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic [CNT_WIDTH-1:0]  pkt_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t                state;
  logic [DATA_WIDTH-1:0] tail_data;
  logic                  tail_last;
  logic                  push, pop;
  assign push = valid_internal && ready_internal;
  assign pop  = valid && ready_sys;
  // data_out/last are the head entry itself; tail only holds the second beat in FULL
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state          <= EMPTY;
      ready_internal <= 1'b0;
      valid          <= 1'b0;
      data_out       <= '0;
      last           <= 1'b0;
      tail_data      <= '0;
      tail_last      <= 1'b0;
      beat_cnt       <= '0;
      pkt_cnt        <= '0;
    end else begin
      if (pop) begin
        beat_cnt <= last ? '0 : beat_cnt + 1'b1;
        if (last) pkt_cnt <= pkt_cnt + 1'b1;
      end
      case (state)
        EMPTY: begin
          ready_internal <= 1'b1;
          if (push) begin
            state    <= ONE;
            valid    <= 1'b1;
            data_out <= data_in;
            last     <= last_in;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state          <= FULL;
            ready_internal <= 1'b0;
            tail_data      <= data_in;
            tail_last      <= last_in;
          end else if (push) begin
            data_out <= data_in;
            last     <= last_in;
          end else if (pop) begin
            state <= EMPTY;
            valid <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            state          <= ONE;
            ready_internal <= 1'b1;
            data_out       <= tail_data;
            last           <= tail_last;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule
